// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 constants, bit functions and compressor FSM state type
package sha256_pkg;

    typedef enum logic [1:0] {IDLE, ROUND, UPDATE, DONE} Sha256CompState;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] Ch(input logic [31:0] x, y, z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] Maj(input logic [31:0] x, y, z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [31:0] Sigma0(input logic [31:0] x);
        return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
    endfunction

    function automatic logic [31:0] Sigma1(input logic [31:0] x);
        return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
    endfunction

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    // Schedule word W[t+16] from W[t+14], W[t+9], W[t+1], W[t]
    function automatic logic [31:0] sched(input logic [31:0] w14, w9, w1, w0);
        return sigma1(w14) + w9 + sigma0(w1) + w0;
    endfunction

endpackage

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 round; state index 0 is a, 7 is h
module sha256_round
    import sha256_pkg::*;
(
    input  logic [0:7][31:0] s_in,
    input  logic [31:0]      w,
    input  logic [31:0]      k,
    output logic [0:7][31:0] s_out
);

    logic [31:0] t1, t2;

    // Compression round: new a from T1+T2, new e from d+T1, the rest shift down
    always_comb begin
        t1 = s_in[7] + Sigma1(s_in[4]) + Ch(s_in[4], s_in[5], s_in[6]) + k + w;
        t2 = Sigma0(s_in[0]) + Maj(s_in[0], s_in[1], s_in[2]);
        s_out = {t1 + t2, s_in[0], s_in[1], s_in[2], s_in[3] + t1, s_in[4], s_in[5], s_in[6]};
    end

endmodule

// File: rtl/sha256_compressor.sv
// sha256_compressor: SHA-256 compression over a chunk stream; SHA256_COMPRESSOR_UNROLL2_EN runs two rounds per cycle
module sha256_compressor
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         chunk_in_vld,
    output logic         chunk_in_rdy,
    input  logic [511:0] chunk_in,
    input  logic         chunk_in_last,
    output logic         digest_vld,
    input  logic         digest_rdy,
    output logic [255:0] digest
);

    Sha256CompState state, state_nxt;
    logic [0:7][31:0]  hs, vs, vs_nxt, r1;
    logic [0:15][31:0] w, w_nxt;
    logic [5:0]        t;
    logic              last_q;

    sha256_round u_round0 (.s_in(vs), .w(w[0]), .k(K[t]), .s_out(r1));

`ifdef SHA256_COMPRESSOR_UNROLL2_EN
    localparam logic [5:0] T_STEP = 6'd2;
    localparam logic [5:0] T_LAST = 6'd62;
    logic [0:7][31:0] r2;
    sha256_round u_round1 (.s_in(r1), .w(w[1]), .k(K[t + 6'd1]), .s_out(r2));
    assign vs_nxt = r2;
    assign w_nxt  = {w[2:15], sched(w[14], w[9], w[1], w[0]), sched(w[15], w[10], w[2], w[1])};
`else
    localparam logic [5:0] T_STEP = 6'd1;
    localparam logic [5:0] T_LAST = 6'd63;
    assign vs_nxt = r1;
    assign w_nxt  = {w[1:15], sched(w[14], w[9], w[1], w[0])};
`endif

    assign chunk_in_rdy = (state == IDLE) & ~rst;
    assign digest_vld   = (state == DONE);
    assign digest       = hs;

    // State register
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = chunk_in_vld ? ROUND : IDLE;
            ROUND:   state_nxt = (t == T_LAST) ? UPDATE : ROUND;
            UPDATE:  state_nxt = last_q ? DONE : IDLE;
            DONE:    state_nxt = digest_rdy ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: chunk load, rounds with schedule window shift, hash update, IV restore
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) hs[i] <= IV[i];
            t      <= '0;
            last_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (chunk_in_vld) begin
                    w      <= chunk_in;
                    vs     <= hs;
                    last_q <= chunk_in_last;
                    t      <= '0;
                end
                ROUND: begin
                    vs <= vs_nxt;
                    w  <= w_nxt;
                    t  <= t + T_STEP;
                end
                UPDATE: for (int i = 0; i < 8; i++) hs[i] <= hs[i] + vs[i];
                DONE: if (digest_rdy) for (int i = 0; i < 8; i++) hs[i] <= IV[i];
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_compressor.sv
// tb_sha256_compressor: directed known-answer checks of sha256_compressor
module tb_sha256_compressor;

`ifdef SHA256_COMPRESSOR_UNROLL2_EN
    localparam int ROUNDS = 32;
    localparam int RST_AT = 15;
`else
    localparam int ROUNDS = 64;
    localparam int RST_AT = 30;
`endif

    localparam logic [255:0] IV_D  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_D = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMP_D = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] TWO_D = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [511:0] ABC_C = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [511:0] EMP_C = {32'h80000000, {15{32'h0}}};
    localparam logic [511:0] TWO_C1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                       32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                       32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                       32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO_C2 = {{15{32'h0}}, 32'h000001c0};

    logic         clk = 0;
    logic         rst = 1;
    logic         chunk_in_vld = 0;
    logic         chunk_in_rdy;
    logic [511:0] chunk_in = '0;
    logic         chunk_in_last = 0;
    logic         digest_vld;
    logic         digest_rdy = 0;
    logic [255:0] digest;

    int cmp = 0;
    int bad = 0;

    sha256_compressor dut (
        .clk(clk), .rst(rst),
        .chunk_in_vld(chunk_in_vld), .chunk_in_rdy(chunk_in_rdy),
        .chunk_in(chunk_in), .chunk_in_last(chunk_in_last),
        .digest_vld(digest_vld), .digest_rdy(digest_rdy), .digest(digest)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a chunk, then optionally check the cycle on which the block completes
    task automatic send(input logic [511:0] c, input logic l, input bit chk_lat, input string nm);
        int n = 0;
        while (!chunk_in_rdy && n < 300) begin tick(); n++; end
        cmp++;
        if (chunk_in_rdy !== 1'b1) begin bad++; $display("FAIL %s accept_rdy: got %b want 1", nm, chunk_in_rdy); end
        chunk_in = c; chunk_in_last = l; chunk_in_vld = 1;
        tick();
        chunk_in_vld = 0; chunk_in = {16{32'hdeadbeef}}; chunk_in_last = ~l;
        if (chk_lat) begin
            repeat (ROUNDS) tick();
            cmp++;
            if (digest_vld !== 1'b0 || chunk_in_rdy !== 1'b0) begin
                bad++; $display("FAIL %s early: vld=%b rdy=%b want 0 0", nm, digest_vld, chunk_in_rdy);
            end
            tick();
            cmp++;
            if (digest_vld !== l || chunk_in_rdy !== ~l) begin
                bad++; $display("FAIL %s latency: vld=%b rdy=%b want %b %b", nm, digest_vld, chunk_in_rdy, l, ~l);
            end
        end
    endtask

    // Wait for the digest, check it, take it, check the handshake closes
    task automatic get_digest(input logic [255:0] exp, input string nm);
        int n = 0;
        while (!digest_vld && n < 300) begin tick(); n++; end
        cmp++;
        if (digest_vld !== 1'b1 || digest !== exp) begin
            bad++; $display("FAIL %s digest: vld=%b got %h want %h", nm, digest_vld, digest, exp);
        end
        digest_rdy = 1;
        tick();
        digest_rdy = 0;
        cmp++;
        if (digest_vld !== 1'b0 || chunk_in_rdy !== 1'b1) begin
            bad++; $display("FAIL %s after_xfer: vld=%b rdy=%b want 0 1", nm, digest_vld, chunk_in_rdy);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) tick();
        cmp++;
        if (chunk_in_rdy !== 1'b0 || digest_vld !== 1'b0) begin
            bad++; $display("FAIL reset_outs: rdy=%b vld=%b want 0 0", chunk_in_rdy, digest_vld);
        end
        cmp++;
        if (digest !== IV_D) begin bad++; $display("FAIL reset_digest: got %h want %h", digest, IV_D); end
        rst = 0;
        #1;
        cmp++;
        if (chunk_in_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy: got %b want 1", chunk_in_rdy); end
    endtask

    task automatic test_abc();
        send(ABC_C, 1, 1, "abc");
        get_digest(ABC_D, "abc");
    endtask

    task automatic test_empty();
        send(EMP_C, 1, 1, "empty");
        get_digest(EMP_D, "empty");
    endtask

    task automatic test_two_chunk();
        send(TWO_C1, 0, 1, "two_c1");
        send(TWO_C2, 1, 1, "two_c2");
        get_digest(TWO_D, "two");
    endtask

    task automatic test_backpressure();
        send(ABC_C, 1, 1, "bp");
        for (int i = 0; i < 10; i++) begin
            cmp++;
            if (digest_vld !== 1'b1 || chunk_in_rdy !== 1'b0 || digest !== ABC_D) begin
                bad++; $display("FAIL bp_hold[%0d]: vld=%b rdy=%b digest=%h want 1 0 %h", i, digest_vld, chunk_in_rdy, digest, ABC_D);
            end
            tick();
        end
        get_digest(ABC_D, "bp");
    endtask

    task automatic test_back_to_back();
        digest_rdy = 1;
        send(ABC_C, 1, 1, "b2b_1");
        get_digest(ABC_D, "b2b_1");
        digest_rdy = 1;
        send(ABC_C, 1, 1, "b2b_2");
        get_digest(ABC_D, "b2b_2");
    endtask

    task automatic test_reset_mid();
        send(TWO_C1, 0, 0, "rst_mid");
        repeat (RST_AT) tick();
        rst = 1;
        tick();
        cmp++;
        if (chunk_in_rdy !== 1'b0 || digest_vld !== 1'b0) begin
            bad++; $display("FAIL rst_mid_outs: rdy=%b vld=%b want 0 0", chunk_in_rdy, digest_vld);
        end
        tick();
        cmp++;
        if (digest !== IV_D) begin bad++; $display("FAIL rst_mid_iv: got %h want %h", digest, IV_D); end
        rst = 0;
        #1;
        cmp++;
        if (chunk_in_rdy !== 1'b1) begin bad++; $display("FAIL rst_mid_rdy: got %b want 1", chunk_in_rdy); end
        send(ABC_C, 1, 1, "rst_mid_abc");
        get_digest(ABC_D, "rst_mid_abc");
    endtask

    initial begin
        test_reset();
        test_abc();
        test_empty();
        test_two_chunk();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule
